time_entry_ctrl: RTL

TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

---
 rtl/time_entry_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/time_entry_ctrl.sv
// Microwave time-entry controller: keypad digit entry, BCD mm:ss countdown,
// door interlock, pause/resume and a timed "done" indication.
module time_entry_ctrl #(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd_in,
    input  logic       loadn,
    input  logic       tick_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic       encoder_enablen,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       magnetron_on,
    output logic       done
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned BTN_W = 4;
    localparam int unsigned CNT_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   min_q, min_d;
    logic [DIG_W-1:0]   tens_q, tens_d;
    logic [DIG_W-1:0]   units_q, units_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BTN_W-1:0]   btn_q, btn_d;
    logic               done_q, done_d;
    logic               enc_q, enc_d;

    logic               load_ev, start_ev, stop_ev, clear_ev;
    logic               digit_ok, start_go, start_ok, time_zero;
    logic [DIG_W-1:0]   dec_min, dec_tens, dec_units;
    logic               dec_zero;

    // Button order in the edge register: {loadn, startn, stopn, clearn}
    assign btn_d    = {loadn, startn, stopn, clearn};
    assign load_ev  = btn_q[3] & ~btn_d[3];
    assign start_ev = btn_q[2] & ~btn_d[2];
    assign stop_ev  = btn_q[1] & ~btn_d[1];
    assign clear_ev = btn_q[0] & ~btn_d[0];

    assign time_zero = (min_q == '0) && (tens_q == '0) && (units_q == '0);
    assign digit_ok  = load_ev && (bcd_in <= DIG_W'(9));
    assign start_go  = start_ev && !stop_ev;
    assign start_ok  = start_go && door_closed && !time_zero;

    // One-second BCD decrement; seconds tens wrap to 5 so entered 6..9 still count down
    always_comb begin
        dec_min   = min_q;
        dec_tens  = tens_q;
        dec_units = units_q - DIG_W'(1);
        if (units_q == '0) begin
            dec_units = DIG_W'(9);
            if (tens_q == '0) begin
                dec_tens = DIG_W'(5);
                dec_min  = min_q - DIG_W'(1);
            end else begin
                dec_tens = tens_q - DIG_W'(1);
            end
        end
        dec_zero = (dec_min == '0) && (dec_tens == '0) && (dec_units == '0);
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        cnt_d   = cnt_q;

        if (clear_ev) begin
            state_d = S_IDLE;
            min_d   = '0;
            tens_d  = '0;
            units_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (digit_ok) begin
                        min_d   = tens_q;
                        tens_d  = units_q;
                        units_d = bcd_in;
                        state_d = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (start_ok) begin
                        state_d = S_COOK;
                    end else if (digit_ok) begin
                        min_d   = tens_q;
                        tens_d  = units_q;
                        units_d = bcd_in;
                    end
                end
                S_COOK: begin
                    if (stop_ev || !door_closed) begin
                        state_d = S_PAUSE;
                    end else if (tick_1hz) begin
                        min_d   = dec_min;
                        tens_d  = dec_tens;
                        units_d = dec_units;
                        if (dec_zero) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_ok) begin
                        state_d = S_COOK;
                    end
                end
                S_DONE: begin
                    if (start_go) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick_1hz) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        done_d = (state_d == S_DONE);
        enc_d  = !((state_d == S_IDLE) || (state_d == S_ENTRY));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            tens_q  <= '0;
            units_q <= '0;
            cnt_q   <= '0;
            btn_q   <= '1;
            done_q  <= 1'b0;
            enc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
        end
    end

    // Heating follows the door and reset with no clock latency
    assign magnetron_on    = (state_q == S_COOK) && door_closed && !reset;
    assign done            = done_q;
    assign encoder_enablen = enc_q;
    assign min_units       = min_q;
    assign sec_tens        = tens_q;
    assign sec_units       = units_q;

endmodule
